// File: rtl/instruction_fetch_phase.sv
// IF stage: owns the PC, fetches words over a req/ready handshake and fills the IF/ID register.
// Handles memory wait states, a one-entry stall buffer and wrong-path discard after redirects.
module instruction_fetch_phase #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        JumpRegister,
    input  logic [31:0] JumpRegTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        if_valid,
    output logic        dbg_state,
    output logic        dbg_kill
);

    // Handshake: a fetch completes on any cycle where imem_req and imem_ready are both high;
    // imem_addr is held constant from the first cycle of imem_req until that cycle.
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        kill, kill_nxt;
    logic [31:0] redir_pc, redir_pc_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] instr_nxt, pc_out_nxt;
    logic        valid_nxt;

    logic        accept;
    logic        redirect;
    logic [31:0] raw_target, target, pc_plus4;

    assign accept   = imem_req & imem_ready;
    assign redirect = (Branch | Jump | JumpRegister) & if_valid & ~Stall;
    assign pc_plus4 = pc + 32'd4;
    assign raw_target = JumpRegister ? JumpRegTarget :
                        Jump         ? JumpTarget    : BranchTarget;
    assign target   = raw_target & ~32'h3;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            redir_pc  <= 32'h0;
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'h0;
            instr_out <= NOP_INSTR;
            pc_out    <= 32'h0;
            if_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            kill      <= kill_nxt;
            redir_pc  <= redir_pc_nxt;
            buf_instr <= buf_instr_nxt;
            buf_pc    <= buf_pc_nxt;
            instr_out <= instr_nxt;
            pc_out    <= pc_out_nxt;
            if_valid  <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        kill_nxt      = kill;
        redir_pc_nxt  = redir_pc;
        buf_instr_nxt = buf_instr;
        buf_pc_nxt    = buf_pc;
        instr_nxt     = instr_out;
        pc_out_nxt    = pc_out;
        valid_nxt     = if_valid;
        case (state)
            FETCH: begin
                if (kill && accept) begin
                    // Wrong-path word from before the redirect: drop it, then fetch the target.
                    pc_nxt   = redir_pc;
                    kill_nxt = 1'b0;
                    if (!Stall) begin
                        instr_nxt = NOP_INSTR;
                        valid_nxt = 1'b0;
                    end
                end else if (redirect && accept) begin
                    pc_nxt    = target;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end else if (redirect) begin
                    redir_pc_nxt = target;
                    kill_nxt     = 1'b1;
                    instr_nxt    = NOP_INSTR;
                    valid_nxt    = 1'b0;
                end else if (accept && !Stall) begin
                    instr_nxt  = imem_rdata;
                    pc_out_nxt = pc_plus4;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc_plus4;
                end else if (accept) begin
                    buf_instr_nxt = imem_rdata;
                    buf_pc_nxt    = pc_plus4;
                    pc_nxt        = pc_plus4;
                    state_nxt     = HOLD;
                end else if (!Stall) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (!Stall) begin
                    state_nxt = FETCH;
                    if (redirect) begin
                        pc_nxt    = target;
                        instr_nxt = NOP_INSTR;
                        valid_nxt = 1'b0;
                    end else begin
                        instr_nxt  = buf_instr;
                        pc_out_nxt = buf_pc;
                        valid_nxt  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        imem_req  = (state == FETCH) && Reset;
        imem_addr = pc;
        dbg_state = (state == HOLD);
        dbg_kill  = kill;
    end

endmodule
